// File: rtl/fwd_source_tracker.sv
// fwd_source_tracker: EX/WB/RT in-flight write tracker answering rs1/rs2 forwarding lookups; ports: clk_in/rst_in, stall_in/flush_in, issue_* (IS instr), rs1_*/rs2_* (IS sources), ex_result_in, wb_load_valid_in/wb_load_data_in -> rsN_hit_out/rsN_data_out, hazard_out, issue_accept_out, wb_hold_out
module fwd_source_tracker #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  input  logic                  issue_valid_in,
  input  logic [REG_ADDR_W-1:0] issue_rd_addr_in,
  input  logic                  issue_rd_we_in,
  input  logic                  issue_is_load_in,
  input  logic [REG_ADDR_W-1:0] rs1_addr_in,
  input  logic                  rs1_used_in,
  input  logic [REG_ADDR_W-1:0] rs2_addr_in,
  input  logic                  rs2_used_in,
  input  logic [XLEN-1:0]       ex_result_in,
  input  logic                  wb_load_valid_in,
  input  logic [XLEN-1:0]       wb_load_data_in,
  output logic                  rs1_hit_out,
  output logic [XLEN-1:0]       rs1_data_out,
  output logic                  rs2_hit_out,
  output logic [XLEN-1:0]       rs2_data_out,
  output logic                  hazard_out,
  output logic                  issue_accept_out,
  output logic                  wb_hold_out
);
  logic                  ex_v, ex_we, ex_ld;
  logic [REG_ADDR_W-1:0] ex_rd;
  logic                  wb_v, wb_we, wb_ld, wb_rdy;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [XLEN-1:0]       wb_data;
  logic                  rt_v, rt_we;
  logic [REG_ADDR_W-1:0] rt_rd;
  logic [XLEN-1:0]       rt_data;
  logic                  wb_blk, adv;
  assign wb_blk = wb_v && wb_ld && !wb_rdy && !wb_load_valid_in;
  assign adv    = !stall_in && !wb_blk;
  for (genvar i = 0; i < 2; i++) begin : g_src
    logic [REG_ADDR_W-1:0] rs;
    logic                  used, live, m_ex, m_wb, m_rt, hz, hit;
    logic [XLEN-1:0]       data;
    assign rs   = i ? rs2_addr_in : rs1_addr_in;
    assign used = i ? rs2_used_in : rs1_used_in;
    always_comb begin
      live = used && rs != '0;
      m_ex = live && ex_v && ex_we && ex_rd == rs;
      m_wb = live && wb_v && wb_we && wb_rd == rs;
      m_rt = live && rt_v && rt_we && rt_rd == rs;
      hz   = m_ex ? ex_ld : m_wb && wb_blk;
      hit  = (m_ex || m_wb || m_rt) && !hz;
      data = !hit ? '0 : m_ex ? ex_result_in : m_wb ? (wb_rdy ? wb_data : wb_load_data_in) : rt_data;
    end
  end
  assign rs1_hit_out      = g_src[0].hit;
  assign rs1_data_out     = g_src[0].data;
  assign rs2_hit_out      = g_src[1].hit;
  assign rs2_data_out     = g_src[1].data;
  assign hazard_out       = issue_valid_in && (g_src[0].hz || g_src[1].hz);
  assign issue_accept_out = adv && issue_valid_in && !hazard_out && !flush_in;
  assign wb_hold_out      = wb_blk;
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ex_v    <= 1'b0;
      wb_v    <= 1'b0;
      wb_rdy  <= 1'b0;
      wb_data <= '0;
      rt_v    <= 1'b0;
      rt_data <= '0;
    end else if (adv) begin
      rt_v    <= wb_v;
      rt_rd   <= wb_rd;
      rt_we   <= wb_we;
      rt_data <= wb_rdy ? wb_data : wb_load_data_in;
      wb_v    <= ex_v;
      wb_rd   <= ex_rd;
      wb_we   <= ex_we;
      wb_ld   <= ex_ld;
      wb_rdy  <= !ex_ld;
      wb_data <= ex_result_in;
      ex_v    <= issue_accept_out;
      ex_rd   <= issue_rd_addr_in;
      ex_we   <= issue_rd_we_in;
      ex_ld   <= issue_is_load_in;
    end else begin
      rt_v <= 1'b0;
      if (wb_v && wb_ld && !wb_rdy && wb_load_valid_in) begin
        wb_rdy  <= 1'b1;
        wb_data <= wb_load_data_in;
      end
    end
  end
endmodule

// File: tb/tb_fwd_source_tracker.sv
// tb_fwd_source_tracker: directed vectors pushed to a scoreboard queue, checked by a negedge monitor
module tb_fwd_source_tracker;
  logic        clk_in = 1'b0;
  logic        rst_in, stall_in, flush_in;
  logic        issue_valid_in, issue_rd_we_in, issue_is_load_in;
  logic [4:0]  issue_rd_addr_in, rs1_addr_in, rs2_addr_in;
  logic        rs1_used_in, rs2_used_in;
  logic [31:0] ex_result_in, wb_load_data_in;
  logic        wb_load_valid_in;
  logic        rs1_hit_out, rs2_hit_out, hazard_out, issue_accept_out, wb_hold_out;
  logic [31:0] rs1_data_out, rs2_data_out;
  typedef struct {
    string       name;
    logic [68:0] v;
  } exp_t;
  exp_t q[$];
  int   passed = 0;
  int   total  = 0;
  fwd_source_tracker #(.XLEN(32), .REG_ADDR_W(5)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .stall_in(stall_in), .flush_in(flush_in),
    .issue_valid_in(issue_valid_in), .issue_rd_addr_in(issue_rd_addr_in),
    .issue_rd_we_in(issue_rd_we_in), .issue_is_load_in(issue_is_load_in),
    .rs1_addr_in(rs1_addr_in), .rs1_used_in(rs1_used_in),
    .rs2_addr_in(rs2_addr_in), .rs2_used_in(rs2_used_in),
    .ex_result_in(ex_result_in), .wb_load_valid_in(wb_load_valid_in),
    .wb_load_data_in(wb_load_data_in),
    .rs1_hit_out(rs1_hit_out), .rs1_data_out(rs1_data_out),
    .rs2_hit_out(rs2_hit_out), .rs2_data_out(rs2_data_out),
    .hazard_out(hazard_out), .issue_accept_out(issue_accept_out), .wb_hold_out(wb_hold_out)
  );
  always #5 clk_in = ~clk_in;
  always @(negedge clk_in) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [68:0] got;
      e   = q.pop_front();
      got = {rs1_hit_out, rs1_data_out, rs2_hit_out, rs2_data_out, hazard_out, issue_accept_out, wb_hold_out};
      total++;
      if (got === e.v) passed++;
      else $display("FAIL %s: got h1=%b d1=%h h2=%b d2=%h hz=%b acc=%b hold=%b, expected h1=%b d1=%h h2=%b d2=%h hz=%b acc=%b hold=%b",
                    e.name, got[68], got[67:36], got[35], got[34:3], got[2], got[1], got[0],
                    e.v[68], e.v[67:36], e.v[35], e.v[34:3], e.v[2], e.v[1], e.v[0]);
    end
  end
  task automatic set(input logic iv, input logic [4:0] rd, input logic we, input logic ld,
                     input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                     input logic [31:0] exr, input logic st, input logic fl,
                     input logic lv, input logic [31:0] lvd);
    issue_valid_in = iv; issue_rd_addr_in = rd; issue_rd_we_in = we; issue_is_load_in = ld;
    rs1_addr_in = r1; rs1_used_in = u1; rs2_addr_in = r2; rs2_used_in = u2;
    ex_result_in = exr; stall_in = st; flush_in = fl;
    wb_load_valid_in = lv; wb_load_data_in = lvd;
  endtask
  task automatic step(input string n, input logic h1, input logic [31:0] d1,
                      input logic h2, input logic [31:0] d2,
                      input logic hz, input logic acc, input logic hold);
    exp_t e;
    e.name = n;
    e.v    = {h1, d1, h2, d2, hz, acc, hold};
    q.push_back(e);
    @(posedge clk_in);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end
  initial begin
    rst_in = 1'b1;
    set(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    set(1, 5, 1, 0, 5, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("reset_state", 0, 0, 0, 0, 0, 1, 0);
    set(1, 6, 1, 1, 5, 1, 0, 0, 32'h10, 0, 0, 0, 32'h0);
    step("b2b_alu", 1, 32'h10, 0, 0, 0, 1, 0);
    set(1, 7, 1, 0, 5, 1, 6, 1, 32'h999, 0, 0, 0, 32'h0);
    step("load_use", 1, 32'h10, 0, 0, 1, 0, 0);
    set(1, 7, 1, 0, 5, 1, 6, 1, 32'h0, 0, 0, 1, 32'hDEADBEEF);
    step("load_data_fwd", 1, 32'h10, 1, 32'hDEADBEEF, 0, 1, 0);
    set(1, 7, 1, 0, 6, 1, 7, 1, 32'h2, 0, 0, 0, 32'h0);
    step("rt_fwd", 1, 32'hDEADBEEF, 1, 32'h2, 0, 1, 0);
    set(1, 0, 1, 0, 7, 1, 0, 1, 32'h1, 0, 0, 0, 32'h0);
    step("priority_ex", 1, 32'h1, 0, 0, 0, 1, 0);
    set(1, 8, 1, 1, 0, 1, 0, 1, 32'h55, 0, 0, 0, 32'h0);
    step("x0_never", 0, 0, 0, 0, 0, 1, 0);
    set(1, 9, 1, 0, 7, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("rt_past_x0", 1, 32'h1, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      set(1, 10, 1, 0, 9, 1, 8, 1, 32'h99, 0, 0, 0, 32'h0);
      step($sformatf("mem_wait%0d", k), 1, 32'h99, 0, 0, 1, 0, 1);
    end
    set(1, 10, 1, 0, 9, 1, 8, 1, 32'h99, 0, 0, 1, 32'hCAFEF00D);
    step("mem_arrive", 1, 32'h99, 1, 32'hCAFEF00D, 0, 1, 0);
    set(0, 0, 0, 0, 8, 1, 9, 1, 32'h77, 0, 0, 0, 32'h0);
    step("rt_load_fwd", 1, 32'hCAFEF00D, 1, 32'h99, 0, 0, 0);
    set(1, 11, 1, 0, 10, 1, 9, 1, 32'h0, 0, 1, 0, 32'h0);
    step("flush", 1, 32'h77, 1, 32'h99, 0, 0, 0);
    set(1, 12, 1, 0, 10, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("after_flush", 1, 32'h77, 0, 0, 0, 1, 0);
    set(1, 13, 1, 0, 12, 1, 0, 0, 32'h12, 0, 0, 0, 32'h0);
    step("issue_b", 1, 32'h12, 0, 0, 0, 1, 0);
    set(1, 14, 1, 0, 13, 1, 12, 1, 32'h13, 0, 0, 0, 32'h0);
    step("pre_stall", 1, 32'h13, 1, 32'h12, 0, 1, 0);
    set(1, 15, 1, 0, 14, 1, 12, 1, 32'h14, 1, 0, 0, 32'h0);
    step("stall1", 1, 32'h14, 1, 32'h12, 0, 0, 0);
    step("stall2_rt_clr", 1, 32'h14, 0, 0, 0, 0, 0);
    set(1, 15, 1, 0, 13, 1, 14, 1, 32'h14, 1, 1, 0, 32'h0);
    step("stall_flush", 1, 32'h13, 1, 32'h14, 0, 0, 0);
    set(0, 0, 0, 0, 13, 1, 14, 1, 32'h14, 0, 0, 0, 32'h0);
    step("unstall", 1, 32'h13, 1, 32'h14, 0, 0, 0);
    set(1, 16, 1, 1, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("ld_issue", 0, 0, 0, 0, 0, 1, 0);
    set(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("ld_to_wb", 0, 0, 0, 0, 0, 0, 0);
    set(0, 0, 0, 0, 16, 1, 0, 0, 32'h0, 1, 0, 1, 32'hA5A5A5A5);
    step("stall_ld_arrive", 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    set(0, 0, 0, 0, 16, 1, 0, 0, 32'h0, 1, 0, 0, 32'hFFFFFFFF);
    step("stall_ld_latched", 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    set(1, 17, 1, 1, 16, 1, 0, 0, 32'h0, 0, 0, 0, 32'h0);
    step("ld_pending", 1, 32'hA5A5A5A5, 0, 0, 0, 1, 0);
    set(0, 0, 0, 0, 16, 1, 17, 1, 32'h0, 0, 0, 0, 32'h0);
    step("hz_gated_by_valid", 1, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
    rst_in = 1'b1;
    set(1, 18, 1, 0, 17, 1, 16, 1, 32'h0, 1, 1, 0, 32'h0);
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    set(1, 18, 1, 0, 17, 1, 16, 1, 32'h0, 0, 0, 0, 32'h0);
    step("post_reset", 0, 0, 0, 0, 0, 1, 0);
    set(1, 19, 1, 0, 17, 1, 16, 1, 32'h0, 1, 0, 0, 32'h0);
    step("post_reset_stall", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_in);
    #1;
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fwd_source_tracker.md
Name: fwd_source_tracker

Overview:
- Producer-side companion to the operand forwarding logic in the Core101 pipeline.
- Tracks in-flight destination writes in three slots, in age order: EX, WB and RT (retired last cycle, not yet visible in the register file).
- Answers rs1/rs2 lookups from the instruction in IS with a hit flag and forwarded data.
- Raises a load-use hazard and controls slot advancement, bubble insertion and flush.

Parameters:
XLEN, 32, datapath width
REG_ADDR_W, 5, register address width

Ports:
clk_in  input  1  clock, rising edge
rst_in  input  1  synchronous reset, active-high
stall_in  input  1  global freeze from memory/control
flush_in  input  1  discard the instruction offered at IS (branch redirect)
issue_valid_in  input  1  IS holds an instruction offered to EX
issue_rd_addr_in  input  REG_ADDR_W  destination of the IS instruction
issue_rd_we_in  input  1  IS instruction writes rd
issue_is_load_in  input  1  IS instruction is a load
rs1_addr_in  input  REG_ADDR_W  IS source 1
rs1_used_in  input  1  source 1 is read
rs2_addr_in  input  REG_ADDR_W  IS source 2
rs2_used_in  input  1  source 2 is read
ex_result_in  input  XLEN  ALU result of the EX slot instruction, valid this cycle
wb_load_valid_in  input  1  load data for the WB slot arrives this cycle
wb_load_data_in  input  XLEN  load data
rs1_hit_out  output  1  forwarded value selected for rs1
rs1_data_out  output  XLEN  forwarded rs1 value
rs2_hit_out  output  1  forwarded value selected for rs2
rs2_data_out  output  XLEN  forwarded rs2 value
hazard_out  output  1  load-use stall request
issue_accept_out  output  1  IS instruction moves to EX at this edge
wb_hold_out  output  1  pipeline held, waiting on load data

Behaviour:
- Slot contents: valid, rd, we, is_load, rdy, data.
- Reset (synchronous, rst_in high at the edge): all slot valid/rdy/data cleared.
  - The cycle after reset, all outputs are 0 except issue_accept_out, which equals issue_valid_in & !flush_in & !stall_in.
  - Reset overrides stall_in and flush_in.
- A slot matches rsN when all of the following hold: valid, we, rd == rsN, rsN != 0, and rsN_used_in.
- Lookup (combinational, per source, youngest first):
  - EX match:
    - EX is a load: hazard, hit=0.
    - Otherwise: hit=1, data=ex_result_in.
  - Else WB match:
    - WB is a load with rdy=0 and !wb_load_valid_in: hazard, hit=0.
    - Otherwise: hit=1, data = rdy ? stored data : wb_load_data_in.
  - Else RT match: hit=1, data = RT data.
  - Else hit=0, data=0.
- hazard_out = issue_valid_in & (hazard on rs1 | hazard on rs2).
- Hold conditions:
  - wb_blk = WB valid & is_load & !rdy & !wb_load_valid_in.
  - wb_hold_out = wb_blk.
  - adv = !stall_in & !wb_blk.
- Advancement at the clock edge when adv=1:
  - RT <= WB (valid = WB valid). Data is the stored data, or wb_load_data_in if that arrives this cycle.
  - WB <= EX. Non-load: data=ex_result_in, rdy=1. Load: rdy=0.
  - EX <= IS instruction if issue_valid_in & !hazard_out & !flush_in; otherwise a bubble (valid=0).
  - issue_accept_out equals exactly that EX-load condition.
- When adv=0:
  - EX and WB hold.
  - RT invalidated (no retirement this cycle).
  - issue_accept_out=0.
  - If wb_load_valid_in arrives during stall_in, the WB slot latches the data and sets rdy=1.
- flush_in:
  - Blocks only the issue; slots already in EX/WB/RT are older and continue.
  - If flush_in and stall_in are both high, nothing advances and no issue occurs.
- Priority between slots: same rd in EX and WB → EX value wins (youngest).
- x0: never forwarded, never causes a hazard.
- Latency:
  - A result is forwardable in the same cycle its producer sits in EX.
  - Load data is forwardable in the cycle it arrives at WB.

Test Plan:
- Back-to-back ALU: EX has addi x5 and ex_result_in=0x00000010; IS reads rs1=x5 → rs1_hit_out=1, rs1_data_out=0x10, hazard_out=0, issue_accept_out=1.
- Load-use: EX holds a load to x6; IS uses rs2=x6 → hazard_out=1, issue_accept_out=0. Next cycle the load is in WB, EX is a bubble. With wb_load_valid_in=1 and data 0xDEADBEEF → rs2_hit_out=1, data 0xDEADBEEF, accept=1.
- Priority and x0:
  - EX and WB both write x7 (ex_result_in=1, WB data=2) → rs1 data=1.
  - rs1=x0 with a slot writing x0 → hit=0, hazard=0.
- Memory wait: WB load not ready and wb_load_valid_in=0 for 3 cycles → wb_hold_out=1 and EX held for those 3 cycles; RT invalid. Data arrives → advance, and the next cycle RT forwards it.
- Flush/stall: flush_in=1 with a valid issue → accept=0, EX bubble. stall_in=1 → all slots frozen, RT cleared. rst_in during a pending load → all hits/hazards 0 next cycle.
